di_stream_term: RTL

Terminal-side stream buffer on the HostInterface `di_*` bus, clocked on `ifclk`. It converts host register transactions into two 16-bit word FIFOs: host writes feed an outbound stream to fabric logic, and fabric logic feeds an inbound stream the host reads. The block sits downstream of HostInterface alongside the other terminals. The top-level terminal mux selects its `di_reg_datao`, `di_read_rdy` and `di_write_rdy` when `di_term_addr` equals `TERM_ADDR`.

---
 rtl/di_stream_term_if.sv | 23 ++
 rtl/di_stream_term.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/di_stream_term_if.sv
// Host-side di_* register bus seen by a stream terminal.
// The host drives the master modport and the terminal implements the slave modport.
interface di_stream_term_if;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [15:0] di_reg_datai;
    logic        di_read_req;
    logic        di_read;
    logic        di_write;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy;
    logic        di_write_rdy;

    modport master (
        output di_term_addr, di_reg_addr, di_reg_datai, di_read_req, di_read, di_write,
        input  di_reg_datao, di_read_rdy, di_write_rdy
    );

    modport slave (
        input  di_term_addr, di_reg_addr, di_reg_datai, di_read_req, di_read, di_write,
        output di_reg_datao, di_read_rdy, di_write_rdy
    );
endinterface

// File: rtl/di_stream_term.sv
// Terminal stream buffer: host writes feed an outbound word FIFO and host reads drain an inbound word FIFO.
// Define DI_STREAM_TERM_STATUS_EN to add the sticky ovf/uvf_in flags readable at register 4.
module di_stream_term #(
    parameter logic [15:0] TERM_ADDR = 16'h0000,
    parameter int          ADDR_W    = 4
) (
    input  logic              ifclk,
    input  logic              reset,
    di_stream_term_if.slave   di,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

    logic              sel, wr_strobe, flush, read_start, live;
    logic [15:0]       out_mem [DEPTH];
    logic [15:0]       in_mem  [DEPTH];
    logic [ADDR_W-1:0] out_wr_ptr, out_rd_ptr, in_wr_ptr, in_rd_ptr;
    logic [ADDR_W:0]   out_count, in_count;
    logic              out_full, in_full, out_push, out_pop, in_push, in_pop;
    rd_state_t         rd_state;
    logic [31:0]       rd_addr;
    logic [15:0]       reg_word, status_word;

    assign sel        = (di.di_term_addr == TERM_ADDR);
    assign wr_strobe  = sel && di.di_write;
    assign flush      = wr_strobe && (di.di_reg_addr == 32'd3);
    assign read_start = sel && di.di_read_req;

    assign out_full = (out_count == FULL_COUNT);
    assign in_full  = (in_count == FULL_COUNT);

    // A same-cycle pop frees the slot, so pushing into a full FIFO is legal then.
    assign out_pop  = out_ready && out_valid;
    assign out_push = wr_strobe && (di.di_reg_addr == 32'd0) && (!out_full || out_pop);
    assign in_pop   = (rd_state == FETCH) && (rd_addr == 32'd0) && (in_count != '0) && !read_start;
    assign in_push  = in_valid && (!in_full || in_pop);

    assign out_valid       = (out_count != '0);
    assign out_data        = out_valid ? out_mem[out_rd_ptr] : 16'h0000;
    assign in_ready        = live && !in_full;
    assign di.di_write_rdy = live && !out_full && !di.di_write;

    always_ff @(posedge ifclk) begin
        if (reset) live <= 1'b0;
        else       live <= 1'b1;
    end

    always_ff @(posedge ifclk) begin
        if (out_push) out_mem[out_wr_ptr] <= di.di_reg_datai;
        if (in_push)  in_mem[in_wr_ptr]   <= in_data;
    end

    always_ff @(posedge ifclk) begin
        if (reset || flush) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
        end else begin
            if (out_push) out_wr_ptr <= out_wr_ptr + ADDR_W'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + ADDR_W'(1);
            if (in_push)  in_wr_ptr  <= in_wr_ptr + ADDR_W'(1);
            if (in_pop)   in_rd_ptr  <= in_rd_ptr + ADDR_W'(1);
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + (ADDR_W+1)'(1);
                2'b01:   out_count <= out_count - (ADDR_W+1)'(1);
                default: out_count <= out_count;
            endcase
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + (ADDR_W+1)'(1);
                2'b01:   in_count <= in_count - (ADDR_W+1)'(1);
                default: in_count <= in_count;
            endcase
        end
    end

`ifdef DI_STREAM_TERM_STATUS_EN
    logic ovf, uvf_in, ovf_set, uvf_set, status_clr;

    assign ovf_set    = wr_strobe && (di.di_reg_addr == 32'd0) && out_full && !out_pop;
    assign uvf_set    = in_valid && in_full && !in_pop;
    assign status_clr = wr_strobe && (di.di_reg_addr == 32'd4);

    // A set beats a same-cycle write-1-clear so no event is lost.
    always_ff @(posedge ifclk) begin
        if (reset || flush) begin
            ovf    <= 1'b0;
            uvf_in <= 1'b0;
        end else begin
            if (ovf_set)                            ovf    <= 1'b1;
            else if (status_clr && di.di_reg_datai[0]) ovf    <= 1'b0;
            if (uvf_set)                            uvf_in <= 1'b1;
            else if (status_clr && di.di_reg_datai[1]) uvf_in <= 1'b0;
        end
    end

    assign status_word = {14'b0, uvf_in, ovf};
`else
    assign status_word = 16'h0000;
`endif

    always_comb begin
        reg_word = 16'h0000;
        case (rd_addr)
            32'd1:   reg_word = {{(15-ADDR_W){1'b0}}, in_count};
            32'd2:   reg_word = {{(15-ADDR_W){1'b0}}, out_count};
            32'd4:   reg_word = status_word;
            default: reg_word = 16'h0000;
        endcase
    end

    // A new request restarts the fetch from any state, so a held word is simply abandoned.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            rd_state        <= IDLE;
            rd_addr         <= '0;
            di.di_reg_datao <= 16'h0000;
            di.di_read_rdy  <= 1'b0;
        end else if (flush) begin
            rd_state       <= IDLE;
            di.di_read_rdy <= 1'b0;
        end else if (read_start) begin
            rd_state       <= FETCH;
            rd_addr        <= di.di_reg_addr;
            di.di_read_rdy <= 1'b0;
        end else begin
            case (rd_state)
                FETCH: begin
                    if (rd_addr != 32'd0) begin
                        di.di_reg_datao <= reg_word;
                        di.di_read_rdy  <= 1'b1;
                        rd_state        <= HOLD;
                    end else if (in_count != '0) begin
                        di.di_reg_datao <= in_mem[in_rd_ptr];
                        di.di_read_rdy  <= 1'b1;
                        rd_state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (sel && di.di_read) begin
                        di.di_read_rdy <= 1'b0;
                        rd_state       <= IDLE;
                    end
                end
                default: begin
                    di.di_read_rdy <= 1'b0;
                    rd_state       <= IDLE;
                end
            endcase
        end
    end
endmodule
